// File: rtl/dffram_port_arbiter.sv
// ============================================================================
// Module   : dffram_port_arbiter
// Purpose  : Shares one single-port DFFRAM between a pipelined CPU port and a
//            slow read-only housekeeping port. Bounded-wait priority lets a
//            pending housekeeping read override a continuous CPU stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dffram_port_arbiter #(
  parameter int AW       = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic          core_clk,
  input  logic          core_rst,
  // CPU port
  input  logic          cpu_req,
  input  logic [3:0]    cpu_wen,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [31:0]   cpu_rdata,
  // Housekeeping read-only port
  input  logic          ro_req,
  input  logic [AW-1:0] ro_addr,
  output logic          ro_ack,
  output logic [31:0]   ro_data,
  output logic          ro_starved,
  // DFFRAM macro
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_di,
  input  logic [31:0]   ram_do
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_RD    = 2'd1;
  localparam logic [1:0] c_ST_CAP   = 2'd2;
  localparam logic [7:0] c_MAX_WAIT = 8'(MAX_WAIT);

  logic [1:0]  r_state;
  logic [7:0]  r_wait_cnt;
  logic        r_starved;
  logic        r_cpu_rvalid;
  logic [31:0] r_ro_data;

  logic        w_ro_elig;
  logic        w_ro_force;
  logic        w_gnt_cpu;
  logic        w_gnt_ro;
  logic [1:0]  w_state_nxt;
  logic [7:0]  w_wait_nxt;

  // Arbitration: a starved RO request beats the CPU, otherwise CPU wins ties.
  // Grants are suppressed while reset is held so the RAM sees no access.
  always_comb begin
    w_ro_elig  = ro_req && (r_state == c_ST_IDLE);
    w_ro_force = w_ro_elig && (r_wait_cnt >= c_MAX_WAIT);
    w_gnt_cpu  = !core_rst && cpu_req && !w_ro_force;
    w_gnt_ro   = !core_rst && w_ro_elig && (w_ro_force || !cpu_req);
  end

  // RAM request mux; the RO path is hard-wired to read-only.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 4'b0000;
    ram_addr = '0;
    ram_di   = 32'd0;
    if (w_gnt_cpu) begin
      ram_en   = 1'b1;
      ram_we   = cpu_wen;
      ram_addr = cpu_addr;
      ram_di   = cpu_wdata;
    end else if (w_gnt_ro) begin
      ram_en   = 1'b1;
      ram_addr = ro_addr;
    end
  end

  // RO FSM next state: one grant walks IDLE -> RD -> CAP -> IDLE, so a held
  // ro_req level cannot issue a second read before the ack.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (w_gnt_ro) w_state_nxt = c_ST_RD;
      c_ST_RD:   w_state_nxt = c_ST_CAP;
      c_ST_CAP:  w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Saturating wait counter: counts lost arbitrations of an eligible RO request.
  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (w_gnt_ro) begin
      w_wait_nxt = 8'd0;
    end else if ((r_state == c_ST_IDLE) && !ro_req) begin
      w_wait_nxt = 8'd0;
    end else if (w_ro_elig && (r_wait_cnt < c_MAX_WAIT)) begin
      w_wait_nxt = r_wait_cnt + 8'd1;
    end
  end

  // State, counter, response and capture registers.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      r_state      <= c_ST_IDLE;
      r_wait_cnt   <= 8'd0;
      r_starved    <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_ro_data    <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait_cnt   <= w_wait_nxt;
      r_starved    <= (w_wait_nxt >= c_MAX_WAIT);
      r_cpu_rvalid <= w_gnt_cpu;
      if (r_state == c_ST_RD) begin
        r_ro_data <= ram_do;
      end
    end
  end

  // Response pulses are masked during reset so nothing leaks out mid-reset.
  always_comb begin
    cpu_gnt    = w_gnt_cpu;
    cpu_rvalid = r_cpu_rvalid && !core_rst;
    cpu_rdata  = ram_do;
    ro_ack     = (r_state == c_ST_CAP) && !core_rst;
    ro_data    = r_ro_data;
    ro_starved = r_starved && !core_rst;
  end

endmodule

`default_nettype wire
